// File: rtl/mvm_host_driver.sv
// Host-side sequencer for a k x k matrix-vector unit: buffers one job from the host,
// replays it to the MVM as load/compute commands, then drains the k result words.
module mvm_host_driver #(
    parameter int k       = 4,
    parameter int b       = 6,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [b-1:0]     in_data,
    output logic             mvm_loadMatrix,
    output logic             mvm_loadVector,
    output logic             mvm_start,
    output logic [b-1:0]     mvm_data_in,
    input  logic             mvm_done,
    input  logic [2*b-1:0]   mvm_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*b-1:0]   out_data,
    output logic             busy,
    output logic             timeout
);

    localparam int KK = k * k;
    localparam int N  = KK + k;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (k > 1) ? $clog2(k) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        LDM_CMD,
        LDM_DATA,
        LDV_CMD,
        LDV_DATA,
        START,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [RW-1:0]   ridx;
    logic [TW-1:0]   wcnt;
    logic [b-1:0]    job_mem [N];
    logic [2*b-1:0]  res_mem [k];

    always_comb begin
        in_ready = (state == IDLE) || (state == FILL);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            ridx           <= '0;
            wcnt           <= '0;
            mvm_loadMatrix <= 1'b0;
            mvm_loadVector <= 1'b0;
            mvm_start      <= 1'b0;
            mvm_data_in    <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            timeout        <= 1'b0;
        end else begin
            // Command strobes and the MVM data bus default low so every pulse lasts one cycle.
            mvm_loadMatrix <= 1'b0;
            mvm_loadVector <= 1'b0;
            mvm_start      <= 1'b0;
            mvm_data_in    <= '0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        job_mem[0] <= in_data;
                        idx        <= AW'(1);
                        timeout    <= 1'b0;
                        state      <= FILL;
                    end
                end

                FILL: begin
                    if (in_valid) begin
                        job_mem[idx] <= in_data;
                        if (idx == AW'(N - 1)) begin
                            idx            <= '0;
                            mvm_loadMatrix <= 1'b1;
                            state          <= LDM_CMD;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end

                LDM_CMD: begin
                    mvm_data_in <= job_mem[0];
                    idx         <= AW'(1);
                    state       <= LDM_DATA;
                end

                // idx is the number of words already placed on the bus in this phase.
                LDM_DATA: begin
                    if (idx == AW'(KK)) begin
                        idx            <= '0;
                        mvm_loadVector <= 1'b1;
                        state          <= LDV_CMD;
                    end else begin
                        mvm_data_in <= job_mem[idx];
                        idx         <= idx + AW'(1);
                    end
                end

                LDV_CMD: begin
                    mvm_data_in <= job_mem[AW'(KK)];
                    idx         <= AW'(1);
                    state       <= LDV_DATA;
                end

                LDV_DATA: begin
                    if (idx == AW'(k)) begin
                        idx       <= '0;
                        mvm_start <= 1'b1;
                        state     <= START;
                    end else begin
                        mvm_data_in <= job_mem[AW'(KK) + idx];
                        idx         <= idx + AW'(1);
                    end
                end

                START: begin
                    wcnt  <= '0;
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (mvm_done) begin
                        wcnt  <= '0;
                        ridx  <= '0;
                        state <= CAPTURE;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        wcnt    <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                end

                // The MVM streams results unconditionally, so capture never stalls.
                CAPTURE: begin
                    res_mem[ridx] <= mvm_data_out;
                    if (ridx == RW'(k - 1)) begin
                        ridx      <= '0;
                        out_valid <= 1'b1;
                        out_data  <= (k == 1) ? mvm_data_out : res_mem[0];
                        state     <= DRAIN;
                    end else begin
                        ridx <= ridx + RW'(1);
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (ridx == RW'(k - 1)) begin
                            ridx      <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            state     <= IDLE;
                        end else begin
                            ridx     <= ridx + RW'(1);
                            out_data <= res_mem[ridx + RW'(1)];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        $onehot0({mvm_loadMatrix, mvm_loadVector, mvm_start}));

    assert property (@(posedge clk) disable iff (!reset) in_ready |-> !out_valid);

endmodule

// File: doc/mvm_host_driver.md
MVM_HOST_DRIVER -- requirements
Module: mvm_host_driver

Interface
REQ-001 SHALL have parameter k, default 4, meaning matrix dimension (k x k matrix, k-element vector).
REQ-002 SHALL have parameter b, default 6, meaning input word width in bits (signed).
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for mvm_done.
REQ-004 SHALL provide ports, one per line:
  clk             input   1     clock; all state updates on rising edge
  reset           input   1     synchronous, active-low reset
  in_valid        input   1     host word valid
  in_ready        output  1     driver accepts host word
  in_data         input   b     host word (signed)
  mvm_loadMatrix  output  1     one-cycle matrix-load command to the MVM
  mvm_loadVector  output  1     one-cycle vector-load command to the MVM
  mvm_start       output  1     one-cycle compute command to the MVM
  mvm_data_in     output  b     word streamed to the MVM data input
  mvm_done        input   1     MVM completion pulse
  mvm_data_out    input   2b    MVM result word (signed)
  out_valid       output  1     result word valid
  out_ready       input   1     consumer accepts result word
  out_data        output  2b    result word (signed)
  busy            output  1     driver not in IDLE
  timeout         output  1     sticky flag: last job aborted waiting for mvm_done

Function
REQ-005 SHALL implement these FSM states: IDLE, FILL, LDM_CMD, LDM_DATA, LDV_CMD, LDV_DATA, START, WAIT_DONE, CAPTURE, DRAIN.
REQ-006 SHALL accept a host word when in_valid & in_ready; in_ready = 1 only in IDLE and FILL.
REQ-007 SHALL treat the job as k*k matrix words (row-major) followed by k vector words, stored in a (k*k+k)-entry buffer in acceptance order.
REQ-008 SHALL move IDLE->FILL on the first accepted word, and move FILL->LDM_CMD in the cycle after the (k*k+k)-th accepted word.
REQ-009 In LDM_CMD, SHALL assert mvm_loadMatrix for exactly one cycle.
REQ-010 In LDM_DATA, SHALL drive the k*k matrix words on mvm_data_in on k*k consecutive cycles, starting the cycle after mvm_loadMatrix.
REQ-011 SHALL then assert mvm_loadVector for exactly one cycle (LDV_CMD).
REQ-012 SHALL then drive the k vector words on k consecutive cycles (LDV_DATA).
REQ-013 SHALL then assert mvm_start for exactly one cycle (START) and enter WAIT_DONE.
REQ-014 SHALL drive mvm_data_in to 0 in every cycle outside LDM_DATA and LDV_DATA.
REQ-015 SHALL keep mvm_loadMatrix, mvm_loadVector and mvm_start mutually exclusive, and SHALL register all three.
REQ-016 When mvm_done = 1 in cycle D during WAIT_DONE, SHALL capture mvm_data_out in cycles D+1..D+k into a k-entry result buffer (CAPTURE), with no backpressure toward the MVM.
REQ-017 SHALL ignore mvm_done outside WAIT_DONE.
REQ-018 In DRAIN, SHALL hold out_valid = 1 with out_data = the current result.
REQ-019 In DRAIN, SHALL advance to the next result on out_valid & out_ready.
REQ-020 SHALL return to IDLE after the k-th result handshake.
REQ-021 SHALL hold out_data stable while out_valid & ~out_ready.
REQ-022 SHALL pass result words through without modification: no truncation, no sign change.
REQ-023 SHALL count WAIT_DONE cycles; on reaching TIMEOUT without mvm_done, SHALL go to IDLE, set timeout = 1 and discard the job.
REQ-024 SHALL clear timeout on the next accepted host word.
REQ-025 SHALL keep busy = 1 in every state except IDLE.
REQ-026 SHALL never overlap jobs: no host word is accepted from LDM_CMD through DRAIN.
REQ-027 SHALL wrap all counters to 0 when they leave their state.

Reset
REQ-028 While reset = 0 at a rising edge, SHALL enter IDLE and clear all counters, buffer indices and timeout.
REQ-029 Reset SHALL drive mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in, out_valid, out_data and busy to 0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation (any state) SHALL abort the job with no further MVM command pulses and no partial results emitted.

Verification
REQ-032 Identity: A = I (k=4), x = [1,2,3,4], behavioural MVM model -> one pulse each of loadMatrix, loadVector and start at the required spacing; out_data = 1,2,3,4 in order.
REQ-033 Input throttling: in_valid toggles every other cycle for the same job -> identical MVM stream and results; in_ready stays 1 throughout FILL.
REQ-034 Output backpressure: A all -8, x all 7, out_ready low for 5 cycles -> out_data holds -224 while stalled; exactly four -224 results delivered.
REQ-035 Timeout: MVM model never asserts mvm_done -> 64 cycles after mvm_start, timeout = 1, busy = 0, in_ready = 1; timeout clears on the next accepted word.
REQ-036 Reset mid-stream: reset = 0 during the 8th LDM_DATA cycle -> next cycle all command outputs 0, busy = 0, out_valid = 0; a following full job completes correctly.
REQ-037 Spurious done: mvm_done pulsed during FILL -> ignored; job results unchanged.
